// File: rtl/led_demux_sequencer.sv
// LED demux sequencer: debounced mode/step buttons drive a 4-way demux select and data bit.
// Latency: outputs registered; tick/release responses appear at the edge they are sampled.
// Backpressure: none; events landing together resolve by priority and the losers are dropped.
module led_demux_sequencer #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Tick,
    input  logic       i_Switch_1,
    input  logic       i_Switch_2,
    output logic [1:0] o_Sel,
    output logic       o_Data,
    output logic [1:0] o_Mode,
    output logic       o_Paused
);

    localparam int CW = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);

    typedef enum logic [1:0] {
        MANUAL    = 2'b00,
        SCAN_UP   = 2'b01,
        SCAN_DOWN = 2'b10,
        BAD       = 2'b11
    } mode_t;

    logic [1:0]         w_raw;
    logic [1:0]         r_db;
    logic [1:0]         r_db_q;
    logic [1:0][CW-1:0] r_cnt;
    logic [1:0]         w_rel;

    mode_t      r_mode;
    mode_t      w_mode_nxt;
    logic       w_enter;
    logic [1:0] r_sel;
    logic       r_data;
    logic       r_paused;
    logic [1:0] w_sel_nxt;
    logic       w_data_nxt;
    logic       w_paused_nxt;

    assign w_raw = {i_Switch_2, i_Switch_1};

    // Counter only runs while raw disagrees with the accepted level.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_db   <= '0;
            r_db_q <= '0;
            r_cnt  <= '0;
        end else begin
            r_db_q <= r_db;
            for (int i = 0; i < 2; i++) begin
                if (w_raw[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_db[i]  <= w_raw[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_rel = r_db_q & ~r_db;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_mode <= MANUAL;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    always_comb begin
        w_mode_nxt = r_mode;
        case (r_mode)
            MANUAL:    if (w_rel[0]) w_mode_nxt = SCAN_UP;
            SCAN_UP:   if (w_rel[0]) w_mode_nxt = SCAN_DOWN;
            SCAN_DOWN: if (w_rel[0]) w_mode_nxt = MANUAL;
            default:   w_mode_nxt = MANUAL;
        endcase
    end

    // Any mode change (including recovery from 11) reloads the entry values.
    assign w_enter = (w_mode_nxt != r_mode);

    always_comb begin
        w_sel_nxt    = r_sel;
        w_data_nxt   = r_data;
        w_paused_nxt = r_paused;
        if (w_enter) begin
            w_sel_nxt    = 2'b00;
            w_paused_nxt = 1'b0;
            w_data_nxt   = (w_mode_nxt != MANUAL);
        end else if (w_rel[1]) begin
            if (r_mode == MANUAL) begin
                w_sel_nxt = r_sel + 2'd1;
            end else begin
                w_paused_nxt = ~r_paused;
            end
        end else if (i_Tick) begin
            case (r_mode)
                MANUAL:    w_data_nxt = ~r_data;
                SCAN_UP:   if (!r_paused) w_sel_nxt = r_sel + 2'd1;
                SCAN_DOWN: if (!r_paused) w_sel_nxt = r_sel - 2'd1;
                default:   w_sel_nxt = r_sel;
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_sel    <= 2'b00;
            r_data   <= 1'b0;
            r_paused <= 1'b0;
        end else begin
            r_sel    <= w_sel_nxt;
            r_data   <= w_data_nxt;
            r_paused <= w_paused_nxt;
        end
    end

    assign o_Sel    = r_sel;
    assign o_Data   = r_data;
    assign o_Mode   = r_mode;
    assign o_Paused = r_paused;

endmodule

// File: doc/led_demux_sequencer.md
LED_DEMUX_SEQUENCER -- requirements
Module: led_demux_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_LIMIT, default 250000, meaning consecutive stable cycles needed to accept a new switch level (≥2).
REQ-002 SHALL have port i_Clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port i_Rst_L  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_Tick  input  1  one-cycle step pulse, driven from the LFSR done strobe.
REQ-005 SHALL have port i_Switch_1  input  1  raw mode button, high while pressed.
REQ-006 SHALL have port i_Switch_2  input  1  raw step/pause button, high while pressed.
REQ-007 SHALL have port o_Sel  output  2  demux select: bit0 to i_Sel0, bit1 to i_Sel1.
REQ-008 SHALL have port o_Data  output  1  demux data bit.
REQ-009 SHALL have port o_Mode  output  2  current mode encoding.
REQ-010 SHALL have port o_Paused  output  1  high while scanning is paused.

Function
REQ-011 SHALL debounce each switch independently: the debounced level takes the raw level only after the raw level differs from it for DEBOUNCE_LIMIT consecutive cycles; the counter clears whenever raw equals debounced.
REQ-012 SHALL generate a one-cycle release pulse per switch on each debounced 1->0 transition, one cycle after the debounced level changes.
REQ-013 SHALL implement a mode FSM: MANUAL (00) -> SCAN_UP (01) -> SCAN_DOWN (10) -> MANUAL on each Switch_1 release pulse; encoding 11 is unreachable and SHALL recover to MANUAL on the next cycle.
REQ-014 On mode entry, o_Sel SHALL load 00, o_Paused SHALL load 0, and o_Data SHALL load 0 for MANUAL or 1 for scan modes, all at the same edge as o_Mode.
REQ-015 In MANUAL, each i_Tick SHALL invert o_Data with o_Sel held, and each Switch_2 release pulse SHALL increment o_Sel modulo 4 (11->00).
REQ-016 In SCAN_UP with o_Paused=0, each i_Tick SHALL increment o_Sel modulo 4 (11->00) with o_Data held at 1.
REQ-017 In SCAN_DOWN with o_Paused=0, each i_Tick SHALL decrement o_Sel modulo 4 (00->11) with o_Data held at 1.
REQ-018 In scan modes, each Switch_2 release pulse SHALL invert o_Paused; while paused, i_Tick SHALL be ignored.
REQ-019 Latency: o_Sel/o_Data SHALL update at the first rising edge on which i_Tick or the release pulse is sampled high; all outputs SHALL be registered.
REQ-020 Simultaneous events SHALL resolve by priority: Switch_1 release, then Switch_2 release, then i_Tick. Lower-priority events in the same cycle SHALL be discarded, not queued.
REQ-021 i_Tick held high for N cycles SHALL act as N ticks.

Reset
REQ-022 While i_Rst_L=0, asynchronously and without waiting for a clock edge: o_Mode=00, o_Sel=00, o_Data=0, o_Paused=0, debounced levels=0, debounce counters=0.
REQ-023 Reset asserted mid-operation SHALL abort any pending debounce count; after deassertion, a switch already held high SHALL need a full DEBOUNCE_LIMIT cycles before it is recognised.
REQ-024 First tick or release-pulse response SHALL be possible on the first rising edge after i_Rst_L rises.

Verification (DEBOUNCE_LIMIT=4)
REQ-025 Reset, then 3 i_Tick pulses in MANUAL -> o_Data 0->1->0->1, o_Sel stays 00, o_Mode=00.
REQ-026 Switch_1 high 3 cycles, then low -> no mode change; high 10 cycles, then low 10 cycles -> o_Mode=01, o_Sel=00, o_Data=1, o_Paused=0.
REQ-027 SCAN_UP, 5 ticks -> o_Sel 01,10,11,00,01; then advance to SCAN_DOWN, 2 ticks -> o_Sel 11,10.
REQ-028 SCAN_UP, Switch_2 press/release -> o_Paused=1, 3 ticks leave o_Sel unchanged; second release -> o_Paused=0, next tick increments o_Sel.
REQ-029 Switch_1 release pulse and i_Tick in the same cycle in SCAN_UP with o_Sel=10 -> o_Mode=10, o_Sel=00 (tick discarded).
REQ-030 Assert i_Rst_L=0 between clock edges in SCAN_DOWN with o_Sel=11 -> all outputs go to reset values before the next edge; Switch_1 held high through reset needs 4 post-reset cycles to be recognised.
